// File: rtl/ip_pkg.sv
// Shared types and constants for the IPv4 transmit path.
package ip_pkg;

    localparam int IP_HDR_BYTES = 20;
    localparam int IP_MIN_DGRAM = 46;

    localparam int TOTLEN_MSB = 143;
    localparam int TOTLEN_LSB = 128;

    typedef logic [159:0] ip_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_PAD    = 3'd3,
        ST_DROP   = 3'd4
    } ip_state_t;

    function automatic logic [15:0] hdr_tot_len(input ip_hdr_t hdr);
        return hdr[TOTLEN_MSB:TOTLEN_LSB];
    endfunction

endpackage

// File: rtl/ip_byte_outreg.sv
// Single-entry registered byte stage; holds data/valid/last while the sink stalls.
module ip_byte_outreg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_last,
    output logic       o_ready,
    input  logic       i_m_ready,
    output logic [7:0] o_m_data,
    output logic       o_m_valid,
    output logic       o_m_last
);

    logic       r_valid;
    logic [7:0] r_data;
    logic       r_last;

    // The slot frees up in the same cycle the sink takes the current byte.
    assign o_ready = !r_valid || i_m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= 8'h00;
            r_last  <= 1'b0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_m_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign o_m_data  = r_data;
    assign o_m_valid = r_valid;
    assign o_m_last  = r_last;

endmodule

// File: rtl/ip_tx_serializer.sv
// Serialises a 20-byte IPv4 header plus payload into a byte stream with last marker.
// Define IP_TX_PAD_EN to zero-pad short datagrams up to MIN_DGRAM bytes.
//
// Handshakes: a byte moves on any interface when valid && ready are both high at
// the rising edge; a producer holds its payload stable while valid && !ready.
module ip_tx_serializer
    import ip_pkg::*;
#(
    parameter int HDR_BYTES = IP_HDR_BYTES,
    parameter int MIN_DGRAM = IP_MIN_DGRAM
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [159:0] ip_header,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        len_err,
    output logic        busy,
    output ip_state_t   o_dbg_state
);

`ifdef IP_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    ip_state_t   r_state;
    ip_state_t   w_state_nxt;
    ip_hdr_t     r_hdr_sr;
    logic [15:0] r_pay_len;
    logic [15:0] r_cnt;

    logic        w_out_valid;
    logic [7:0]  w_out_data;
    logic        w_out_last;
    logic        w_or_ready;
    logic        w_push;
    logic        w_hdr_hs;
    logic        w_s_hs;
    logic [15:0] w_tot_len;
    logic        w_tot_short;
    logic        w_hdr_last;
    logic        w_cnt_hit;
    logic        w_need_pad;
    logic        w_pad_last;

    assign w_tot_len   = hdr_tot_len(ip_header);
    assign w_tot_short = w_tot_len < 16'(HDR_BYTES);
    assign w_hdr_last  = r_cnt == 16'(HDR_BYTES - 1);
    assign w_cnt_hit   = (r_cnt + 16'd1) == r_pay_len;
    assign w_need_pad  = PAD_ON && (r_pay_len < 16'(MIN_DGRAM - HDR_BYTES));
    assign w_pad_last  = r_cnt == 16'(MIN_DGRAM - 1);

    assign w_hdr_hs = hdr_valid && hdr_ready;
    assign w_s_hs   = s_valid && s_ready;
    assign w_push   = w_out_valid && w_or_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_hdr_hs) w_state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                if (w_push && w_hdr_last) w_state_nxt = (r_pay_len != 16'd0) ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                if (w_s_hs) begin
                    if (s_last && w_cnt_hit)  w_state_nxt = w_need_pad ? ST_PAD : ST_IDLE;
                    else if (s_last)          w_state_nxt = ST_IDLE;
                    else if (w_cnt_hit)       w_state_nxt = ST_DROP;
                end
            end
`ifdef IP_TX_PAD_EN
            ST_PAD: begin
                if (w_push && w_pad_last) w_state_nxt = ST_IDLE;
            end
`endif
            ST_DROP: begin
                if (s_valid && s_last) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Header byte 0 goes straight into the output stage on accept so that
    // m_valid rises the cycle after the header handshake.
    always_comb begin
        hdr_ready   = 1'b0;
        s_ready     = 1'b0;
        w_out_valid = 1'b0;
        w_out_data  = 8'h00;
        w_out_last  = 1'b0;
        len_err     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                hdr_ready   = !m_valid;
                w_out_valid = hdr_valid && !m_valid;
                w_out_data  = ip_header[159:152];
                len_err     = hdr_valid && !m_valid && w_tot_short;
            end
            ST_HEADER: begin
                w_out_valid = 1'b1;
                w_out_data  = r_hdr_sr[159:152];
                w_out_last  = w_hdr_last && (r_pay_len == 16'd0);
            end
            ST_DATA: begin
                s_ready     = w_or_ready;
                w_out_valid = s_valid && w_or_ready;
                w_out_data  = s_data;
                w_out_last  = (s_last || w_cnt_hit) && !(s_last && w_cnt_hit && w_need_pad);
                len_err     = s_valid && w_or_ready && (s_last != w_cnt_hit);
            end
`ifdef IP_TX_PAD_EN
            ST_PAD: begin
                w_out_valid = 1'b1;
                w_out_data  = 8'h00;
                w_out_last  = w_pad_last;
            end
`endif
            ST_DROP: begin
                s_ready = 1'b1;
            end
            default: ;
        endcase
    end

    // r_cnt: header byte index, then payload count, then total bytes while padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_sr  <= '0;
            r_pay_len <= 16'd0;
            r_cnt     <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hdr_hs) begin
                        r_hdr_sr  <= {ip_header[151:0], 8'h00};
                        r_pay_len <= w_tot_short ? 16'd0 : (w_tot_len - 16'(HDR_BYTES));
                        r_cnt     <= 16'd1;
                    end
                end
                ST_HEADER: begin
                    if (w_push) begin
                        r_hdr_sr <= {r_hdr_sr[151:0], 8'h00};
                        r_cnt    <= w_hdr_last ? 16'd0 : (r_cnt + 16'd1);
                    end
                end
                ST_DATA: begin
                    if (w_s_hs) begin
                        if (s_last && w_cnt_hit && w_need_pad) r_cnt <= r_pay_len + 16'(HDR_BYTES);
                        else                                   r_cnt <= r_cnt + 16'd1;
                    end
                end
`ifdef IP_TX_PAD_EN
                ST_PAD: begin
                    if (w_push) r_cnt <= r_cnt + 16'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    ip_byte_outreg u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (w_out_valid),
        .i_data    (w_out_data),
        .i_last    (w_out_last),
        .o_ready   (w_or_ready),
        .i_m_ready (m_ready),
        .o_m_data  (m_data),
        .o_m_valid (m_valid),
        .o_m_last  (m_last)
    );

    assign busy        = r_state != ST_IDLE;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ip_tx_serializer.sv
// Bench for ip_tx_serializer: directed and random datagrams against a byte-list model.
// Follows IP_TX_PAD_EN so the model pads exactly when the design does.
module tb_ip_tx_serializer;
    import ip_pkg::*;

`ifdef IP_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [159:0] ip_header = '0;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic        len_err;
    logic        busy;
    ip_state_t   dbg_state;

    ip_tx_serializer dut (
        .clk(clk), .rst_n(rst_n), .ip_header(ip_header), .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .len_err(len_err), .busy(busy), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int first_cyc, last_cyc, hs_cyc;
    int err_cnt, stall_bad, idle_bad;
    bit chk_idle;
    int mr_mode = 0;
    bit exp_err;

    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] pay[$];

    bit         prev_stall = 1'b0;
    bit         prev_lasths = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // m_ready pattern: 0 = always ready, 1 = toggle, 2 = random 75 %.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ~m_ready;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Output collector and protocol observers, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall  = 1'b0;
            prev_lasths = 1'b0;
        end else begin
            if (prev_stall && !(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last))
                stall_bad++;
            if (prev_lasths && chk_idle && hdr_ready !== 1'b1) idle_bad++;
            if (len_err === 1'b1) err_cnt++;
            if (m_valid && m_ready) begin
                if (got_q.size() == 0) first_cyc = cyc;
                last_cyc = cyc;
                got_q.push_back({m_last, m_data});
            end
            prev_stall  = m_valid && !m_ready;
            prev_data   = m_data;
            prev_last   = m_last;
            prev_lasths = m_valid && m_ready && m_last;
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Datagram = header bytes, then min(sent, pay_len) payload bytes, optional zero pad.
    task automatic build_model(input logic [159:0] h, input int n);
        int tot, pl, k;
        logic [8:0] t;
        tot = int'(h[143:128]);
        pl  = (tot < 20) ? 0 : tot - 20;
        exp_q.delete();
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, h[159-8*i -: 8]});
        k = (pl == 0) ? 0 : ((n < pl) ? n : pl);
        for (int i = 0; i < k; i++) exp_q.push_back({1'b0, pay[i]});
        if (PAD_ON && pl > 0 && n == pl)
            while (exp_q.size() < 46) exp_q.push_back(9'h000);
        t = exp_q.pop_back();
        t[8] = 1'b1;
        exp_q.push_back(t);
        exp_err = (tot < 20) || (pl > 0 && n != pl);
    endtask

    // ---------------- driver ----------------
    task automatic send_header(input string tag, input logic [159:0] h);
        int b;
        @(posedge clk);
        #1;
        ip_header = h;
        hdr_valid = 1'b1;
        b = 0;
        @(negedge clk);
        while (hdr_ready !== 1'b1 && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk({tag, "_hdr_timeout"}, 32'(b < 200), 32'd1);
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
        ip_header = {$urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic run_dgram(input string tag, input logic [15:0] tot, input int n,
                             input int mode, input bit incr);
        logic [159:0] h;
        int pl, b, m;
        h = {$urandom, $urandom, $urandom, $urandom, $urandom};
        h[159:128] = {8'h45, 8'h00, tot};
        pl = (tot < 16'd20) ? 0 : int'(tot) - 20;
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(incr ? 8'(i + 1) : 8'($urandom_range(0, 255)));
        build_model(h, n);
        got_q.delete();
        err_cnt = 0;
        stall_bad = 0;
        idle_bad = 0;
        chk_idle = !(pl > 0 && n > pl);
        mr_mode = mode;

        send_header(tag, h);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = pay[i];
            s_last  = (i == n - 1);
            b = 0;
            @(negedge clk);
            while (s_ready !== 1'b1 && b < 500) begin
                @(negedge clk);
                b++;
            end
            if (b >= 500) begin
                chk({tag, "_s_timeout"}, 32'(b), 32'd0);
                break;
            end
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        b = 0;
        while (!(got_q.size() >= exp_q.size() && hdr_ready === 1'b1) && b < 2000) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_drain_timeout"}, 32'(b < 2000), 32'd1);
        chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_byte%0d", tag, i + 1), 32'(got_q[i]), 32'(exp_q[i]));
        chk({tag, "_len_err_pulses"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_stall_hold"}, 32'(stall_bad), 32'd0);
        chk({tag, "_idle_after_last"}, 32'(idle_bad), 32'd0);
        if (mode == 0) begin
            chk({tag, "_first_latency"}, 32'(first_cyc - hs_cyc), 32'd1);
            chk({tag, "_no_bubble"}, 32'(last_cyc - first_cyc), 32'(got_q.size() - 1));
        end
        mr_mode = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int b, tot, pl, n, v;
        logic [159:0] h;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid",   32'(m_valid),   32'd0);
        chk("rst_m_last",    32'(m_last),    32'd0);
        chk("rst_m_data",    32'(m_data),    32'd0);
        chk("rst_s_ready",   32'(s_ready),   32'd0);
        chk("rst_hdr_ready", 32'(hdr_ready), 32'd1);
        chk("rst_len_err",   32'(len_err),   32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_dgram("basic",    16'd28, 8, 0, 1'b1);
        run_dgram("stall",    16'd28, 8, 1, 1'b1);
        run_dgram("short",    16'd30, 6, 0, 1'b1);
        run_dgram("long",     16'd24, 9, 0, 1'b1);
        run_dgram("tot_lt20", 16'd10, 0, 0, 1'b0);
        run_dgram("hdr_only", 16'd20, 0, 0, 1'b0);
        run_dgram("one_pay",  16'd21, 1, 2, 1'b0);

        // Reset in the middle of the header stream.
        mr_mode = 0;
        got_q.delete();
        h = {$urandom, $urandom, $urandom, $urandom, $urandom};
        h[159:128] = {8'h45, 8'h00, 16'd28};
        send_header("rst_mid", h);
        b = 0;
        while (got_q.size() < 9 && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("rst_mid_reach", 32'(b < 200), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_m_valid",   32'(m_valid),   32'd0);
        chk("rst_mid_m_last",    32'(m_last),    32'd0);
        chk("rst_mid_m_data",    32'(m_data),    32'd0);
        chk("rst_mid_s_ready",   32'(s_ready),   32'd0);
        chk("rst_mid_hdr_ready", 32'(hdr_ready), 32'd1);
        chk("rst_mid_busy",      32'(busy),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_dgram("after_rst", 16'd28, 8, 0, 1'b1);

        // Random datagrams: exact, short and long payloads under random back-pressure.
        for (int it = 0; it < 10; it++) begin
            tot = $urandom_range(21, 60);
            pl  = tot - 20;
            v   = $urandom_range(0, 2);
            if (v == 1 && pl > 1) n = pl - $urandom_range(1, pl - 1);
            else if (v == 2)      n = pl + $urandom_range(1, 4);
            else                  n = pl;
            run_dgram($sformatf("rnd%0d", it), 16'(tot), n, $urandom_range(0, 2), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ip_tx_serializer.md
# ip_tx_serializer

Byte-serial transmit stage directly downstream of the IP header builder. Accepts one 160-bit IPv4 header (checksum already filled in) plus a payload byte stream. Emits the complete datagram as a valid/ready byte stream with a last marker: 20 header bytes in network order, then payload. Feeds the Ethernet MAC framer.

## Interface
Parameters:
- HDR_BYTES, 20: IPv4 header length in bytes, fixed because IHL = 5.
- MIN_DGRAM, 46: minimum datagram length in bytes when padding is enabled.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ip_header  in  160  header from the builder; bits [159:152] are sent first.
- hdr_valid  in  1  header is present on ip_header.
- hdr_ready  out  1  block can accept a header; high only in IDLE.
- s_data  in  8  payload byte.
- s_valid  in  1  payload byte is valid.
- s_last  in  1  marks the last payload byte.
- s_ready  out  1  block accepts a payload byte.
- m_data  out  8  output byte to the MAC.
- m_valid  out  1  output byte is valid.
- m_last  out  1  marks the last byte of the datagram.
- m_ready  in  1  MAC accepts the output byte.
- len_err  out  1  one-cycle pulse on a length mismatch.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, HEADER, DATA, PAD, DROP.
- IDLE: on hdr_valid && hdr_ready, register ip_header.
  - tot_len = ip_header[143:128]; pay_len = tot_len − 20.
  - If tot_len < 20, set pay_len = 0 and pulse len_err.
  - Go to HEADER.
- HEADER: emit the 20 header bytes MSB-first from a shift register.
  - When the 20th byte handshakes: go to DATA if pay_len > 0, else finish.
- DATA: pass payload bytes through, counting them against pay_len.
  - s_last before the count is reached (short payload): that byte gets m_last, len_err pulses, return to IDLE.
  - Count reached without s_last (long payload): that byte gets m_last, len_err pulses, go to DROP.
  - Count reached together with s_last: normal end.
- DROP: s_ready = 1, m_valid = 0; discard input until s_last is accepted, then go to IDLE.
- Finish: m_last marks the final byte; after its handshake, return to IDLE.
- Counters are 16-bit unsigned. Comparisons use the full width; no wrap is possible because pay_len ≤ 65515.
- The header is latched at accept. Changes on ip_header afterwards are ignored.

## Timing
- Reset values: m_valid = 0, m_last = 0, m_data = 0, s_ready = 0, hdr_ready = 1, len_err = 0, busy = 0, state = IDLE.
- Reset mid-datagram aborts immediately. No partial-frame marker is emitted.
- Output is a registered stage. m_data, m_valid and m_last are held stable while m_valid && !m_ready.
- First header byte: m_valid rises the cycle after the header handshake.
- Throughput is 1 byte/clk while m_ready = 1 and s_valid = 1. No bubble between the last header byte and the first payload byte.
- s_ready = (state == DATA) && (!m_valid || m_ready), or 1 in DROP.
- m_ready low stalls all states except DROP with no loss.
- hdr_ready returns high the cycle after the final m_last handshake. The minimum gap between back-to-back datagrams is one idle cycle.
- len_err is asserted in the same cycle the mismatching byte is accepted on the input.

## Configuration
- IP_TX_PAD_EN defined: applies when tot_len < MIN_DGRAM and payload ended normally.
  - After the last payload byte, go to PAD and emit 0x00 bytes until MIN_DGRAM bytes total have been sent.
  - m_last moves to the final pad byte.
  - Padding does not change the header's tot_len.
- IP_TX_PAD_EN undefined: the PAD state and its counter logic are absent. Datagrams shorter than 46 bytes are emitted unpadded; the MAC pads.

## Structure
- Shared package ip_pkg holds:
  - state enum;
  - IP_HDR_BYTES = 20 and IP_MIN_DGRAM = 46;
  - header field bit positions (TOTLEN_MSB = 143, TOTLEN_LSB = 128);
  - the 160-bit header type.
- One natural sub-module: ip_byte_outreg, the single-entry registered output stage with valid/ready hold logic. The FSM and counters stay in the top.

## Test plan
- Header tot_len = 28 plus 8 payload bytes 0x01..0x08, m_ready = 1 → 28 consecutive bytes starting 0x45, 0x00, 0x00, 0x1C; m_last on byte 28 (0x08); len_err = 0.
- Same datagram with m_ready toggling 1-0-1-0 → identical byte sequence; m_data held stable during stalls; no byte lost or repeated.
- tot_len = 30 with s_last on payload byte 6 → m_last on output byte 26; len_err pulses once; hdr_ready high the next cycle.
- tot_len = 24 with 9 payload bytes → m_last on byte 24; len_err pulses; remaining 5 bytes consumed with m_valid = 0.
- With IP_TX_PAD_EN, tot_len = 28 → 46 bytes out; bytes 29..46 are 0x00; m_last on byte 46. Without the macro → 28 bytes.
- rst_n low during header byte 10 → all outputs at reset values the same cycle; the next header is accepted normally and starts with 0x45.
